// File: rtl/rob_epoch_tracker_pkg.sv
// Shared ROB pointer types and sizing, common to the epoch tracker, epoch generator and younger-than logic.
package rob_epoch_tracker_pkg;
   localparam int YROT_WIDTH_DEF = 9;
   localparam int NUM_DECODE_DEF = 4;
   localparam int NUM_COMMIT_DEF = 4;
   localparam int ROB_DEPTH      = 1 << YROT_WIDTH_DEF;

   // {wrap, index}: the extra MSB separates "empty" from "full" and orders epochs across a wrap.
   typedef logic [YROT_WIDTH_DEF:0] yrot_t;
endpackage

// File: rtl/rob_epoch_tracker_ptr_add.sv
// Wrap-aware {wrap, idx} adder: the carry out of the index field lands in the wrap bit.
module rob_ptr_add #(
   parameter int W = 9
) (
   input  logic [W:0] ptr,
   input  logic [W:0] inc,
   output logic [W:0] sum
);
   assign sum = ptr + inc;
endmodule

// File: rtl/rob_epoch_tracker.sv
// ROB tail/head allocation pointers plus youngest-branch epoch, feeding the branch epoch generator.
module rob_epoch_tracker
   import rob_epoch_tracker_pkg::*;
#(
   parameter int YROT_WIDTH = YROT_WIDTH_DEF,
   parameter int NUM_DECODE = NUM_DECODE_DEF,
   parameter int NUM_COMMIT = NUM_COMMIT_DEF,
   localparam int CW        = $clog2(NUM_COMMIT + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_DECODE-1:0] dec_valid_vec,
   input  logic [NUM_DECODE-1:0] dec_branch_vec,
   output logic                  dec_ready,
   output logic [YROT_WIDTH-1:0] branch_tail,
   output logic                  wrap_bit,
   output logic [YROT_WIDTH:0]   last_epoch,
   output logic [YROT_WIDTH-1:0] branch_head,
   output logic                  head_wrap,
   input  logic [CW-1:0]         commit_cnt,
   input  logic                  squash_valid,
   input  logic [YROT_WIDTH:0]   squash_idx,
   input  logic [YROT_WIDTH:0]   squash_epoch,
   output logic [YROT_WIDTH:0]   rob_count
);
   localparam int DEPTH = 1 << YROT_WIDTH;
   typedef logic [YROT_WIDTH:0] ptr_t;

   ptr_t tail_reg, head_reg, epoch_reg;
   ptr_t count_w, free_w;
   ptr_t dec_n, br_k;
   logic br_any;
   ptr_t commit_w, commit_eff;
   ptr_t tail_adv, head_adv, squash_tail, branch_epoch;
   logic ready_w, accept;

   assign count_w = tail_reg - head_reg;
   assign free_w  = ptr_t'(DEPTH) - count_w;
   assign ready_w = (free_w >= ptr_t'(NUM_DECODE));
   assign accept  = ready_w & (|dec_valid_vec) & ~squash_valid;

   // Slot count and highest valid branch slot; popcount tolerates a non-contiguous vector.
   always_comb begin
      dec_n  = '0;
      br_k   = '0;
      br_any = 1'b0;
      for (int i = 0; i < NUM_DECODE; i++) begin
         if (dec_valid_vec[i]) dec_n = dec_n + ptr_t'(1);
         if (dec_valid_vec[i] && dec_branch_vec[i]) begin
            br_any = 1'b1;
            br_k   = ptr_t'(i);
         end
      end
   end

   // Over-commit is clamped so head can never pass tail.
   assign commit_w   = ptr_t'(commit_cnt);
   assign commit_eff = (commit_w > count_w) ? count_w : commit_w;

   rob_ptr_add #(.W(YROT_WIDTH)) u_tail_add (.ptr(tail_reg),   .inc(dec_n),      .sum(tail_adv));
   rob_ptr_add #(.W(YROT_WIDTH)) u_head_add (.ptr(head_reg),   .inc(commit_eff), .sum(head_adv));
   rob_ptr_add #(.W(YROT_WIDTH)) u_sq_add   (.ptr(squash_idx), .inc(ptr_t'(1)),  .sum(squash_tail));
   rob_ptr_add #(.W(YROT_WIDTH)) u_ep_add   (.ptr(tail_reg),   .inc(br_k),       .sum(branch_epoch));

   always_ff @(posedge clk) begin
      if (reset) begin
         tail_reg  <= '0;
         head_reg  <= '0;
         epoch_reg <= '0;
      end else begin
         head_reg <= head_adv;
         if (squash_valid) begin
            tail_reg  <= squash_tail;
            epoch_reg <= squash_epoch;
         end else if (accept) begin
            tail_reg <= tail_adv;
            if (br_any) epoch_reg <= branch_epoch;
         end
      end
   end

   assign dec_ready   = ready_w;
   assign branch_tail = tail_reg[YROT_WIDTH-1:0];
   assign wrap_bit    = tail_reg[YROT_WIDTH];
   assign last_epoch  = epoch_reg;
   assign branch_head = head_reg[YROT_WIDTH-1:0];
   assign head_wrap   = head_reg[YROT_WIDTH];
   assign rob_count   = count_w;

   logic [NUM_DECODE-1:0] valid_inc;
   ptr_t                  squash_off;
   assign valid_inc  = dec_valid_vec + {{(NUM_DECODE-1){1'b0}}, 1'b1};
   assign squash_off = squash_idx - head_reg;

   a_valid_contig: assert property (@(posedge clk) disable iff (reset)
      (dec_valid_vec & valid_inc) == '0);
   a_commit_range: assert property (@(posedge clk) disable iff (reset)
      commit_w <= count_w);
   a_squash_range: assert property (@(posedge clk) disable iff (reset)
      squash_valid |-> (squash_off < count_w));
endmodule

// File: tb/tb_rob_epoch_tracker.sv
// Directed-vector bench for rob_epoch_tracker at YROT_WIDTH=3 (8-entry ROB), 4 decode, 4 commit.
module tb_rob_epoch_tracker;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] dec_valid_vec, dec_branch_vec;
   logic       dec_ready;
   logic [2:0] branch_tail, branch_head;
   logic       wrap_bit, head_wrap;
   logic [3:0] last_epoch, squash_idx, squash_epoch, rob_count;
   logic [2:0] commit_cnt;
   logic       squash_valid;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   rob_epoch_tracker #(.YROT_WIDTH(3), .NUM_DECODE(4), .NUM_COMMIT(4)) dut (
      .clk(clk), .reset(reset),
      .dec_valid_vec(dec_valid_vec), .dec_branch_vec(dec_branch_vec),
      .dec_ready(dec_ready), .branch_tail(branch_tail), .wrap_bit(wrap_bit),
      .last_epoch(last_epoch), .branch_head(branch_head), .head_wrap(head_wrap),
      .commit_cnt(commit_cnt), .squash_valid(squash_valid),
      .squash_idx(squash_idx), .squash_epoch(squash_epoch), .rob_count(rob_count)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // tail/head given as full {wrap, idx} values
   task automatic check_state(input string tag, input int tail, input int head,
                              input int ep, input int cnt, input int rdy);
      check({tag, ".tail"},  {wrap_bit, branch_tail}, tail);
      check({tag, ".head"},  {head_wrap, branch_head}, head);
      check({tag, ".epoch"}, last_epoch, ep);
      check({tag, ".count"}, rob_count, cnt);
      check({tag, ".ready"}, dec_ready, rdy);
   endtask

   task automatic step(input string tag, input logic rst, input logic [3:0] v,
                       input logic [3:0] b, input logic [2:0] cc, input logic sq,
                       input logic [3:0] si, input logic [3:0] se);
      reset = rst; dec_valid_vec = v; dec_branch_vec = b; commit_cnt = cc;
      squash_valid = sq; squash_idx = si; squash_epoch = se;
      @(posedge clk);
      #1;
      $display("%-10s rst=%b v=%b b=%b cc=%0d sq=%b -> tail=%0d head=%0d ep=%0d cnt=%0d rdy=%b",
               tag, rst, v, b, cc, sq, {wrap_bit, branch_tail}, {head_wrap, branch_head},
               last_epoch, rob_count, dec_ready);
   endtask

   initial begin
      step("reset0", 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
      step("reset1", 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
      step("idle", 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      check_state("idle", 0, 0, 0, 0, 1);

      step("dec_br2", 0, 4'b1111, 4'b0100, 0, 0, 0, 0);
      check_state("dec_br2", 4, 0, 2, 4, 1);

      step("commit4", 0, 4'b0000, 4'b0000, 4, 0, 0, 0);
      check_state("commit4", 4, 4, 2, 0, 1);
      step("dec2", 0, 4'b0011, 4'b0000, 0, 0, 0, 0);
      check_state("dec2", 6, 4, 2, 2, 1);

      // tail 6 + 4 crosses the ROB end; branch in slot 3 sits at 6+3 = {1,1}
      step("wrap", 0, 4'b1111, 4'b1000, 0, 0, 0, 0);
      check_state("wrap", 10, 4, 9, 6, 0);

      step("cnt5", 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
      check_state("cnt5", 10, 5, 9, 5, 0);
      step("blocked", 0, 4'b1111, 4'b0001, 0, 0, 0, 0);
      check_state("blocked", 10, 5, 9, 5, 0);
      step("free4", 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
      check_state("free4", 10, 6, 9, 4, 1);

      step("full", 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
      check_state("full", 14, 6, 9, 8, 0);
      step("drain1", 0, 4'b0000, 4'b0000, 4, 0, 0, 0);
      check_state("drain1", 14, 10, 9, 4, 1);
      step("drain2", 0, 4'b0000, 4'b0000, 4, 0, 0, 0);
      check_state("drain2", 14, 14, 9, 0, 1);

      step("rst_b", 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
      step("fill4", 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
      step("fill6", 0, 4'b0011, 4'b0000, 0, 0, 0, 0);
      check_state("fill6", 6, 0, 0, 6, 0);
      // squash beats decode, commit still retires one entry
      step("squash", 0, 4'b1111, 4'b0000, 1, 1, 4'd2, 4'd1);
      check_state("squash", 3, 1, 1, 2, 1);

      step("run1", 0, 4'b1111, 4'b0000, 2, 0, 0, 0);
      check_state("run1", 7, 3, 1, 4, 1);
      step("run2", 0, 4'b1111, 4'b0010, 4, 0, 0, 0);
      check_state("run2", 11, 7, 8, 4, 1);
      step("run3", 0, 4'b0011, 4'b0000, 0, 0, 0, 0);
      check_state("run3", 13, 7, 8, 6, 0);

      step("midrst", 1, 4'b1111, 4'b0001, 1, 1, 4'd8, 4'd5);
      check_state("midrst", 0, 0, 0, 0, 1);
      step("post", 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      check_state("post", 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rob_epoch_tracker.md
# rob_epoch_tracker

Tracks the ROB allocation pointers (tail and head, each with a wrap bit) and the most recent speculation epoch across decode groups. Sits directly upstream of the branch epoch generator and supplies its `branch_tail`, `wrap_bit` and `last_epoch` inputs. Advances the tail on accepted decode groups and the head on commit. Restores tail and epoch on a branch squash. Gates decode with a registered-state ready signal.

## Interface
- `YROT_WIDTH`, 9: ROB index width. ROB depth is 2^YROT_WIDTH. Epochs and pointers carry one extra wrap MSB.
- `NUM_DECODE`, 4: decode slots per cycle.
- `NUM_COMMIT`, 4: maximum entries retired per cycle.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `dec_valid_vec`  in  NUM_DECODE: valid slots. Must be contiguous from slot 0.
- `dec_branch_vec`  in  NUM_DECODE: slot holds a branch. Ignored where valid=0.
- `dec_ready`  out  1: group may be accepted this cycle.
- `branch_tail`  out  YROT_WIDTH: ROB index that slot 0 will occupy.
- `wrap_bit`  out  1: wrap bit of `branch_tail`.
- `last_epoch`  out  YROT_WIDTH+1: {wrap, index} of the youngest branch allocated so far.
- `branch_head`  out  YROT_WIDTH: oldest ROB index.
- `head_wrap`  out  1: wrap bit of `branch_head`.
- `commit_cnt`  in  $clog2(NUM_COMMIT+1): number of entries retired this cycle.
- `squash_valid`  in  1: mispredict recovery.
- `squash_idx`  in  YROT_WIDTH+1: {wrap, index} of the youngest surviving entry.
- `squash_epoch`  in  YROT_WIDTH+1: epoch to restore, as supplied by the ROB for the surviving entry.
- `rob_count`  out  YROT_WIDTH+1: current occupancy, 0..2^YROT_WIDTH.

## Operation
- State: `tail_ptr` {wrap, idx}, `head_ptr` {wrap, idx}, `last_epoch_q`. All are (YROT_WIDTH+1)-bit.
- Occupancy: `rob_count = tail_ptr - head_ptr` modulo 2^(YROT_WIDTH+1).
  - Empty: count == 0.
  - Full: count == 2^YROT_WIDTH.
- `dec_ready = (2^YROT_WIDTH - rob_count) >= NUM_DECODE`. Depends only on registered state; no commit bypass.
- Accept: `dec_ready & |dec_valid_vec & ~squash_valid`. Let `n = popcount(dec_valid_vec)`.
  - `tail_ptr <= tail_ptr + n`, evaluated in YROT_WIDTH+1 bits so the wrap bit flips on crossing 2^YROT_WIDTH.
  - If any valid slot is a branch, let k be the highest such slot. Then `last_epoch_q <= tail_ptr + k` in YROT_WIDTH+1 bits. This equals the generator's per-slot {wrap, index} for slot k.
  - Otherwise `last_epoch_q` is unchanged.
- Commit: `head_ptr <= head_ptr + min(commit_cnt, rob_count)`, in YROT_WIDTH+1 bits.
  - `commit_cnt > rob_count` is illegal. Flag it with an assertion; the design clamps.
- Squash: `tail_ptr <= squash_idx + 1` and `last_epoch_q <= squash_epoch`.
  - Squash has priority over decode; the decode group in the same cycle is dropped.
  - Commit in the same cycle still applies.
  - `squash_idx` must lie within [head, tail). Outside that range is an assertion error.
- Non-contiguous `dec_valid_vec` is an assertion error. The design uses popcount regardless.

## Timing
- Reset: `tail_ptr = head_ptr = 0`, `last_epoch = 0`, `rob_count = 0`, `dec_ready = 1`. All pointer outputs are 0.
- All outputs are registered, or combinational only from registered state. Updates are visible the cycle after the causing event.
- Decode → visible tail/epoch: 1 cycle, so back-to-back groups are supported at full rate.
- Commit frees space; `dec_ready` rises the cycle after.
- Reset mid-operation overrides squash, decode and commit in the same cycle.

## Structure
- The shared package holds the `yrot_t` typedef (logic [YROT_WIDTH:0]) and a `ROB_DEPTH` constant. Both are shared with the epoch generator and the younger-than logic.
- One sub-module, `rob_ptr_add`: wrap-aware {wrap, idx} adder with an increment input. Instantiated for tail advance, head advance, squash restore and the branch-slot epoch.
- The highest-set-branch selector is an inline loop, not a module.

## Test plan
(Bench configuration: YROT_WIDTH=3, NUM_DECODE=4, NUM_COMMIT=4.)
- Reset, then idle → tail=0, head=0, wrap=0, last_epoch=0, rob_count=0, dec_ready=1.
- From tail {0,0}: valid=1111, branch=0100 → next cycle tail={0,4}, last_epoch={0,2}, rob_count=4.
- Wrap-around: head={0,4}, tail={0,6}, valid=1111, branch=1000 → tail={1,2}, last_epoch={1,1}, rob_count=6.
- Ready gating:
  - rob_count=5 → dec_ready=0, and a valid group is not accepted.
  - commit_cnt=1 → next cycle rob_count=4, dec_ready=1.
  - rob_count=8 → full, dec_ready=0.
- Simultaneous events: head={0,0}, tail={0,6}, squash_idx={0,2}, squash_epoch={0,1}, valid=1111, commit_cnt=1 → tail={0,3}, head={0,1}, last_epoch={0,1}, rob_count=2, decode dropped.
- Reset mid-stream: tail={1,5}, squash and decode asserted with reset → next cycle all state zero, dec_ready=1.
